// File: rtl/des_sched_pkg.sv
// Shared constants for the DES request scheduler: FSM encoding, wrapper selector codes, wrapper latency.
// Latency: n/a (constants only).
// Backpressure: n/a.
package des_sched_pkg;

    localparam logic [3:0] ST_IDLE  = 4'd0;
    localparam logic [3:0] ST_LK0   = 4'd1;
    localparam logic [3:0] ST_LK1   = 4'd2;
    localparam logic [3:0] ST_LD0   = 4'd3;
    localparam logic [3:0] ST_LD1   = 4'd4;
    localparam logic [3:0] ST_START = 4'd5;
    localparam logic [3:0] ST_WAIT  = 4'd6;
    localparam logic [3:0] ST_RHI   = 4'd7;
    localparam logic [3:0] ST_RLO   = 4'd8;
    localparam logic [3:0] ST_RESP  = 4'd9;

    localparam logic [1:0] SEL_KEY_LO  = 2'b00;
    localparam logic [1:0] SEL_KEY_HI  = 2'b01;
    localparam logic [1:0] SEL_DATA_LO = 2'b10;
    localparam logic [1:0] SEL_DATA_HI = 2'b11;

    // Cycles from the start edge until the wrapper first shows ready.
    localparam int WRAP_LAT = 4;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first requester after ptr (modulo N_REQ) wins; one-hot grant plus index.
// Latency: purely combinational.
// Backpressure: none; caller decides when the grant is consumed.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  idx,
    output logic             found
);

    // Scan requesters starting just after the last winner, take the first one pending.
    always_comb begin
        int j;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            j = (int'(ptr) + k) % N_REQ;
            if (!found && req[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                idx      = ID_W'(j);
            end
        end
    end

endmodule

// File: rtl/des_req_scheduler.sv
// Shares one DES wrapper between N_REQ requesters: RR grant, 32-bit load/start/readback, tagged 64-bit response.
// Latency: response valid 12 cycles after accept (10 when the key is already loaded).
// Backpressure: one request in flight; no new grant until the response handshakes.
module des_req_scheduler
    import des_sched_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [64*N_REQ-1:0]   req_key,
    input  logic [64*N_REQ-1:0]   req_data,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ID_W-1:0]       rsp_id,
    output logic [63:0]           rsp_data,
    output logic                  rsp_err,
    output logic [31:0]           des_data_bus,
    output logic [1:0]            des_selector,
    output logic                  des_load,
    output logic                  des_start,
    output logic                  des_result_sel,
    input  logic [31:0]           des_result_out,
    input  logic                  des_ready
);

    localparam int TW = $clog2(TIMEOUT + 1);

    logic [3:0]       state;
    logic [ID_W-1:0]  rr_ptr;
    logic [63:0]      key_q;
    logic [63:0]      data_q;
    logic [63:0]      last_key;
    logic             key_valid;
    logic [TW-1:0]    tcnt;

    logic [N_REQ-1:0] grant;
    logic [ID_W-1:0]  win_idx;
    logic             win_any;
    logic             accept;
    logic [63:0]      win_key;
    logic [63:0]      win_data;

    rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (win_idx),
        .found (win_any)
    );

    // Grant is only offered while idle and never during reset.
    assign accept    = (state == ST_IDLE) && win_any && !rst;
    assign req_ready = accept ? grant : '0;
    assign rsp_valid = (state == ST_RESP);

    // Select the winner's key and data block from the flattened buses.
    always_comb begin
        win_key  = '0;
        win_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win_idx == ID_W'(i)) begin
                win_key  = req_key[i*64 +: 64];
                win_data = req_data[i*64 +: 64];
            end
        end
    end

    // Sequencer: accept, load key/data halves, start, poll ready with timeout, read back, respond.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            rr_ptr    <= ID_W'(N_REQ - 1);
            key_q     <= '0;
            data_q    <= '0;
            last_key  <= '0;
            key_valid <= 1'b0;
            tcnt      <= '0;
            rsp_id    <= '0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        key_q  <= win_key;
                        data_q <= win_data;
                        rsp_id <= win_idx;
                        rr_ptr <= win_idx;
                        state  <= (key_valid && (win_key == last_key)) ? ST_LD0 : ST_LK0;
                    end
                end
                ST_LK0: state <= ST_LK1;
                ST_LK1: begin
                    last_key  <= key_q;
                    key_valid <= 1'b1;
                    state     <= ST_LD0;
                end
                ST_LD0: state <= ST_LD1;
                ST_LD1: state <= ST_START;
                ST_START: begin
                    tcnt  <= '0;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (des_ready) begin
                        state <= ST_RHI;
                    end else if (tcnt == TW'(TIMEOUT - 1)) begin
                        // Wrapper state is unknown after a timeout, so force a key reload next time.
                        rsp_err   <= 1'b1;
                        rsp_data  <= '0;
                        key_valid <= 1'b0;
                        state     <= ST_RESP;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                ST_RHI: begin
                    rsp_data[63:32] <= des_result_out;
                    state           <= ST_RLO;
                end
                ST_RLO: begin
                    rsp_data[31:0] <= des_result_out;
                    state          <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_err <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Wrapper drive: load/start pulses decoded from state; bus is zero outside load states.
    always_comb begin
        des_load       = 1'b0;
        des_start      = 1'b0;
        des_selector   = 2'b00;
        des_data_bus   = '0;
        des_result_sel = 1'b0;
        case (state)
            ST_LK0: begin
                des_load     = 1'b1;
                des_selector = SEL_KEY_LO;
                des_data_bus = key_q[31:0];
            end
            ST_LK1: begin
                des_load     = 1'b1;
                des_selector = SEL_KEY_HI;
                des_data_bus = key_q[63:32];
            end
            ST_LD0: begin
                des_load     = 1'b1;
                des_selector = SEL_DATA_LO;
                des_data_bus = data_q[31:0];
            end
            ST_LD1: begin
                des_load     = 1'b1;
                des_selector = SEL_DATA_HI;
                des_data_bus = data_q[63:32];
            end
            ST_START: des_start      = 1'b1;
            ST_RLO:   des_result_sel = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_des_req_scheduler.sv
// Directed bench for des_req_scheduler with a behavioural DES wrapper attached.
// Latency: checks exact accept-to-response cycle counts.
// Backpressure: exercises held rsp_ready and continuous multi-requester load.
module tb_des_req_scheduler;
    import des_sched_pkg::*;

    localparam int N_REQ   = 4;
    localparam int ID_W    = 2;
    localparam int TIMEOUT = 64;

    localparam logic [63:0] K0   = 64'h1334_5779_9BBC_DFF1;
    localparam logic [63:0] D0   = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] GOLD = 64'h85E8_1354_0F0A_B405;
    localparam logic [63:0] D1   = 64'hFEDC_BA98_7654_3210;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [N_REQ-1:0]     req_valid;
    logic [N_REQ-1:0]     req_ready;
    logic [64*N_REQ-1:0]  req_key;
    logic [64*N_REQ-1:0]  req_data;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [ID_W-1:0]      rsp_id;
    logic [63:0]          rsp_data;
    logic                 rsp_err;
    logic [31:0]          des_data_bus;
    logic [1:0]           des_selector;
    logic                 des_load;
    logic                 des_start;
    logic                 des_result_sel;
    logic [31:0]          des_result_out;
    logic                 des_ready;

    des_req_scheduler #(.N_REQ(N_REQ), .ID_W(ID_W), .TIMEOUT(TIMEOUT)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_key        (req_key),
        .req_data       (req_data),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_id         (rsp_id),
        .rsp_data       (rsp_data),
        .rsp_err        (rsp_err),
        .des_data_bus   (des_data_bus),
        .des_selector   (des_selector),
        .des_load       (des_load),
        .des_start      (des_start),
        .des_result_sel (des_result_sel),
        .des_result_out (des_result_out),
        .des_ready      (des_ready)
    );

    always #5 clk = ~clk;

    // Wrapper transform: the textbook DES vector returns its real ciphertext, any other
    // input returns a cheap keyed scramble so routing errors still show up in the data.
    function automatic logic [63:0] wrap_fn(input logic [63:0] k, input logic [63:0] d);
        if (k == K0 && d == D0) return GOLD;
        return d ^ {k[31:0], k[63:32]} ^ 64'h5A5A_C3C3_0FF0_9669;
    endfunction

    // Behavioural wrapper: captures loads, clears ready on start, raises it WRAP_LAT cycles later.
    logic [63:0] wk, wd, wres;
    logic        wbusy;
    int          wcnt;
    bit          hang = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            des_ready <= 1'b0;
            wbusy     <= 1'b0;
            wcnt      <= 0;
            wres      <= '0;
        end else begin
            if (des_load) begin
                case (des_selector)
                    2'b00: wk[31:0]  <= des_data_bus;
                    2'b01: wk[63:32] <= des_data_bus;
                    2'b10: wd[31:0]  <= des_data_bus;
                    default: wd[63:32] <= des_data_bus;
                endcase
            end
            if (des_start) begin
                des_ready <= 1'b0;
                wres      <= wrap_fn(wk, wd);
                wbusy     <= !hang;
                wcnt      <= WRAP_LAT - 1;
            end else if (wbusy) begin
                if (wcnt == 1) begin
                    des_ready <= 1'b1;
                    wbusy     <= 1'b0;
                end else begin
                    wcnt <= wcnt - 1;
                end
            end
        end
    end

    assign des_result_out = des_result_sel ? wres[31:0] : wres[63:32];

    // Cycle counter and bus monitor.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          grant_id_q[$];
    int          grant_cyc_q[$];
    int          sel_q[$];
    int          rsp_id_q[$];
    logic [63:0] rsp_data_q[$];
    int          rsp_err_q[$];
    int          rsp_cyc_q[$];
    int          v_ls = 0, v_bus = 0, v_oh = 0, v_ovl = 0;

    function automatic int oh_idx(input logic [N_REQ-1:0] v);
        for (int i = 0; i < N_REQ; i++) if (v[i]) return i;
        return -1;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (|(req_valid & req_ready)) begin
                grant_id_q.push_back(oh_idx(req_valid & req_ready));
                grant_cyc_q.push_back(cyc);
            end
            if (des_load) sel_q.push_back(int'(des_selector));
            if (rsp_valid && rsp_ready) begin
                rsp_id_q.push_back(int'(rsp_id));
                rsp_data_q.push_back(rsp_data);
                rsp_err_q.push_back(int'(rsp_err));
                rsp_cyc_q.push_back(cyc);
            end
            if (des_load && des_start) v_ls <= v_ls + 1;
            if (!des_load && des_data_bus != 32'd0) v_bus <= v_bus + 1;
            if ($countones(req_ready) > 1) v_oh <= v_oh + 1;
            if (rsp_valid && |(req_valid & req_ready)) v_ovl <= v_ovl + 1;
        end
    end

    int nchk  = 0;
    int npass = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sync_neg();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_q();
        grant_id_q.delete(); grant_cyc_q.delete(); sel_q.delete();
        rsp_id_q.delete(); rsp_data_q.delete(); rsp_err_q.delete(); rsp_cyc_q.delete();
    endtask

    task automatic set_req(input int i, input logic [63:0] k, input logic [63:0] d);
        req_key[i*64 +: 64]  = k;
        req_data[i*64 +: 64] = d;
    endtask

    task automatic wait_grants(input int n, input string tag);
        int k = 0;
        while (grant_id_q.size() < n && k < 300) begin sync_neg(); k++; end
        chk(tag, 64'(grant_id_q.size()), 64'(n));
    endtask

    task automatic wait_rsps(input int n, input string tag);
        int k = 0;
        while (rsp_id_q.size() < n && k < 300) begin sync_neg(); k++; end
        chk(tag, 64'(rsp_id_q.size()), 64'(n));
    endtask

    task automatic check_reset(input string p);
        chk({p, "_req_ready"}, 64'(req_ready), 64'd0);
        chk({p, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        chk({p, "_rsp_err"},   64'(rsp_err),   64'd0);
        chk({p, "_rsp_id"},    64'(rsp_id),    64'd0);
        chk({p, "_rsp_data"},  rsp_data,       64'd0);
        chk({p, "_des_outs"},  64'({des_data_bus, des_selector, des_load, des_start, des_result_sel}), 64'd0);
    endtask

    logic [63:0] kk[4];
    logic [63:0] dd[4];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end

    initial begin
        int a, bad, rrbad, k;
        logic [63:0] exp1;
        kk[0] = K0;                    dd[0] = 64'h1111_2222_3333_4444;
        kk[1] = 64'h0E32_9232_EA6D_0D73; dd[1] = 64'hA5A5_5A5A_F00F_0FF0;
        kk[2] = 64'h3B38_9872_8E51_CC10; dd[2] = 64'h0000_0000_FFFF_FFFF;
        kk[3] = 64'hDEAD_BEEF_0BAD_F00D; dd[3] = 64'h8000_0000_0000_0001;

        rst = 1'b1; req_valid = '0; rsp_ready = 1'b1; req_key = '0; req_data = '0;

        // Reset: grant suppressed even with a request pending, outputs at reset values after release.
        step(); req_valid = 4'b0001;
        step(); sync_neg();
        chk("rst_req_ready_in_reset", 64'(req_ready), 64'd0);
        step(); rst = 1'b0; req_valid = '0;
        sync_neg();
        check_reset("rst");

        // T1: fresh key on requester 0, known DES vector.
        clear_q(); set_req(0, K0, D0);
        step(); req_valid = 4'b0001;
        wait_grants(1, "t1_grant");
        step(); req_valid = '0;
        wait_rsps(1, "t1_rsp");
        chk("t1_grant_count", 64'(grant_id_q.size()), 64'd1);
        chk("t1_sel_count", 64'(sel_q.size()), 64'd4);
        for (int i = 0; i < 4; i++) chk("t1_sel_order", 64'(sel_q[i]), 64'(i));
        chk("t1_latency", 64'(rsp_cyc_q[0] - grant_cyc_q[0]), 64'd12);
        chk("t1_data", rsp_data_q[0], GOLD);
        chk("t1_id", 64'(rsp_id_q[0]), 64'd0);
        chk("t1_err", 64'(rsp_err_q[0]), 64'd0);

        // T2: same key, new data - key load skipped.
        clear_q(); set_req(0, K0, D1);
        step(); req_valid = 4'b0001;
        wait_grants(1, "t2_grant");
        step(); req_valid = '0;
        wait_rsps(1, "t2_rsp");
        chk("t2_sel_count", 64'(sel_q.size()), 64'd2);
        chk("t2_sel0", 64'(sel_q[0]), 64'd2);
        chk("t2_sel1", 64'(sel_q[1]), 64'd3);
        chk("t2_latency", 64'(rsp_cyc_q[0] - grant_cyc_q[0]), 64'd10);
        chk("t2_data", rsp_data_q[0], wrap_fn(K0, D1));

        // T3: restart pointer, then all four requesters valid continuously.
        step(); rst = 1'b1;
        step(); rst = 1'b0;
        clear_q();
        for (int i = 0; i < 4; i++) set_req(i, kk[i], dd[i]);
        step(); req_valid = 4'b1111;
        wait_grants(5, "t3_grants");
        step(); req_valid = '0;
        wait_rsps(5, "t3_rsps");
        for (int j = 0; j < 5; j++) begin
            chk("t3_grant_id", 64'(grant_id_q[j]), 64'(j % 4));
            chk("t3_rsp_id", 64'(rsp_id_q[j]), 64'(j % 4));
            chk("t3_rsp_data", rsp_data_q[j], wrap_fn(kk[j % 4], dd[j % 4]));
        end
        for (int j = 0; j < 4; j++)
            chk("t3_no_overlap", 64'(rsp_cyc_q[j] < grant_cyc_q[j+1]), 64'd1);

        // T4: response held for 20 cycles; requester 2 waits behind it.
        clear_q(); set_req(1, kk[1], dd[3]); set_req(2, kk[2], dd[0]);
        exp1 = wrap_fn(kk[1], dd[3]);
        step(); rsp_ready = 1'b0; req_valid = 4'b0110;
        wait_grants(1, "t4_grant1");
        chk("t4_first_id", 64'(grant_id_q[0]), 64'd1);
        step(); req_valid = 4'b0100;
        k = 0;
        while (rsp_valid !== 1'b1 && k < 40) begin sync_neg(); k++; end
        chk("t4_rsp_seen", 64'(rsp_valid), 64'd1);
        bad = 0; rrbad = 0;
        for (int c = 0; c < 20; c++) begin
            if (rsp_valid !== 1'b1 || rsp_data !== exp1 || rsp_id !== 2'd1) bad++;
            if (req_ready !== '0) rrbad++;
            sync_neg();
        end
        chk("t4_hold_stable", 64'(bad), 64'd0);
        chk("t4_no_grant_in_resp", 64'(rrbad), 64'd0);
        step(); rsp_ready = 1'b1;
        wait_rsps(1, "t4_rsp1");
        wait_grants(2, "t4_grant2");
        step(); req_valid = '0;
        wait_rsps(2, "t4_rsp2");
        chk("t4_next_id", 64'(grant_id_q[1]), 64'd2);
        chk("t4_next_after_hs", 64'(grant_cyc_q[1] - rsp_cyc_q[0]), 64'd1);
        chk("t4_rsp1_data", rsp_data_q[0], exp1);
        chk("t4_rsp2_data", rsp_data_q[1], wrap_fn(kk[2], dd[0]));
        chk("t4_rsp2_id", 64'(rsp_id_q[1]), 64'd2);

        // T5: wrapper never ready - timeout error, then key reload on the retry.
        clear_q(); hang = 1'b1; set_req(3, kk[3], dd[0]);
        step(); req_valid = 4'b1000;
        wait_grants(1, "t5_grant");
        step(); req_valid = '0;
        wait_rsps(1, "t5_rsp");
        chk("t5_err", 64'(rsp_err_q[0]), 64'd1);
        chk("t5_data_zero", rsp_data_q[0], 64'd0);
        chk("t5_id", 64'(rsp_id_q[0]), 64'd3);
        chk("t5_latency", 64'(rsp_cyc_q[0] - grant_cyc_q[0]), 64'(TIMEOUT + 6));
        hang = 1'b0; clear_q();
        step(); req_valid = 4'b1000;
        wait_grants(1, "t5_retry_grant");
        step(); req_valid = '0;
        wait_rsps(1, "t5_retry_rsp");
        chk("t5_retry_sel_count", 64'(sel_q.size()), 64'd4);
        chk("t5_retry_lk0", 64'(sel_q[0]), 64'd0);
        chk("t5_retry_err", 64'(rsp_err_q[0]), 64'd0);
        chk("t5_retry_data", rsp_data_q[0], wrap_fn(kk[3], dd[0]));

        // T6: reset in WAIT drops the request; next grant restarts at requester 0 with LK0.
        clear_q(); set_req(2, kk[2], dd[2]);
        step(); req_valid = 4'b0100;
        wait_grants(1, "t6_grant");
        a = grant_cyc_q[0];
        step(); req_valid = '0;
        while (cyc < a + 7) step();
        rst = 1'b1;
        step(); rst = 1'b0;
        sync_neg();
        check_reset("t6");
        repeat (10) sync_neg();
        chk("t6_dropped", 64'(rsp_id_q.size()), 64'd0);
        clear_q(); set_req(0, kk[2], dd[1]); set_req(3, kk[1], dd[1]);
        step(); req_valid = 4'b1001;
        wait_grants(1, "t6_regrant");
        step(); req_valid = '0;
        wait_rsps(1, "t6_rsp");
        chk("t6_grant_id", 64'(grant_id_q[0]), 64'd0);
        chk("t6_lk0", 64'(sel_q[0]), 64'd0);
        chk("t6_latency", 64'(rsp_cyc_q[0] - grant_cyc_q[0]), 64'd12);
        chk("t6_data", rsp_data_q[0], wrap_fn(kk[2], dd[1]));

        // Protocol invariants seen by the monitor across the whole run.
        chk("inv_load_start", 64'(v_ls), 64'd0);
        chk("inv_bus_idle_zero", 64'(v_bus), 64'd0);
        chk("inv_ready_onehot", 64'(v_oh), 64'd0);
        chk("inv_grant_during_resp", 64'(v_ovl), 64'd0);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
